// File: rtl/sonic_display.sv
// Multiplexed 4-digit common-anode display for ranger BCD digits, with near-alarm blink and 'n' marker.
// Optional piezo tone while near and lit when NEAR_BUZZER_EN is defined; otherwise buzzer is tied low.
module sonic_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000,
    parameter int TONE_DIV  = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic       near,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       buzzer
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TONE_W  = (TONE_DIV  > 1) ? $clog2(TONE_DIV)  : 1;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_N     = 8'hAB;

    if (SCAN_DIV < 1 || BLINK_DIV < 1 || TONE_DIV < 1) begin : g_param_check
        $error("sonic_display: dividers must be at least 1");
    end

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         idx;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
    logic               phase, phase_n;
    logic [3:0]         s0, s1;
    logic               near_s;

    logic               tick, wrap, lit;
    logic [1:0]         idx_n;
    logic [3:0]         s0_n, s1_n;
    logic               near_n;
    logic [7:0]         slot_seg;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            4'd12:   glyph = SEG_DASH;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    assign tick   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign wrap   = tick && (idx == 2'd3);
    assign idx_n  = idx + 2'd1;
    assign s0_n   = wrap ? num0 : s0;
    assign s1_n   = wrap ? num1 : s1;
    assign near_n = wrap ? near : near_s;

    always_comb begin
        blink_cnt_n = blink_cnt + BLINK_W'(1);
        phase_n     = phase;
        if (!near_s) begin
            blink_cnt_n = '0;
            phase_n     = 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_n = '0;
            phase_n     = ~phase;
        end
    end

    // The slot being latched sees this edge's capture and blink toggle, and a dropped alarm shows steady digits at once.
    assign lit = !near_n || phase_n;

    always_comb begin
        slot_seg = SEG_BLANK;
        case (idx_n)
            2'd0: slot_seg = lit ? glyph(s0_n) : SEG_BLANK;
            2'd1: slot_seg = (lit && !(s1_n == 4'd0 && s0_n <= 4'd9)) ? glyph(s1_n) : SEG_BLANK;
            2'd2: slot_seg = SEG_BLANK;
            2'd3: slot_seg = near_n ? SEG_N : SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= 2'd3;
            blink_cnt <= '0;
            phase     <= 1'b1;
            s0        <= 4'd12;
            s1        <= 4'd12;
            near_s    <= 1'b0;
            seg       <= SEG_BLANK;
            an        <= 4'b1111;
        end else begin
            scan_cnt  <= tick ? '0 : scan_cnt + SCAN_W'(1);
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
            s0        <= s0_n;
            s1        <= s1_n;
            near_s    <= near_n;
            if (tick) begin
                idx <= idx_n;
                seg <= slot_seg;
                an  <= ~(4'b0001 << idx_n);
            end
        end
    end

`ifdef NEAR_BUZZER_EN
    logic [TONE_W-1:0] tone_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (near_s && phase) begin
            if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
                tone_cnt <= '0;
                buzzer   <= ~buzzer;
            end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
            end
        end else begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end
    end
`else
    localparam int TONE_UNBUILT = TONE_W;
    assign buzzer = (TONE_UNBUILT < 0);
`endif

endmodule

// File: tb/tb_sonic_display.sv
// Randomized bench for sonic_display with a slot/frame-level reference model and literal spot checks.
module tb_sonic_display;

    localparam int SD = 4;
    localparam int BD = 32;
    localparam int TD = 2;
`ifdef NEAR_BUZZER_EN
    localparam bit BUZ_EN = 1'b1;
`else
    localparam bit BUZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] num0 = 4'd12;
    logic [3:0] num1 = 4'd12;
    logic       near = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;
    logic       buzzer;

    sonic_display #(.SCAN_DIV(SD), .BLINK_DIV(BD), .TONE_DIV(TD)) dut (
        .clk(clk), .rst(rst), .num0(num0), .num1(num1), .near(near),
        .seg(seg), .an(an), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    localparam logic [7:0] GLY [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] glyph(input int d);
        if (d <= 9) return GLY[d];
        if (d == 12) return 8'hBF;
        return 8'hFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n = clock edges since reset release; slots are SD edges long,
    // frame captures on every fourth slot, blink phase is measured from the capture edge that raised near.
    int n, rise, run;
    int m_s0, m_s1;
    bit m_near;
    logic [7:0] m_seg;
    logic [3:0] m_an;
    bit m_buz;
    int m_idx;

    function automatic bit phase_at(input int t);
        return !m_near || (((t - rise) / BD) % 2 == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0; rise = 0; run = 0;
            m_s0 = 12; m_s1 = 12; m_near = 1'b0;
            m_seg = 8'hFF; m_an = 4'b1111; m_buz = 1'b0; m_idx = 3;
        end else begin
            n++;
            if (m_near && phase_at(n - 1)) run++;
            else run = 0;
            m_buz = BUZ_EN && ((run / TD) % 2 == 1);
            if (n % SD == 0) begin
                m_idx = (3 + n / SD) % 4;
                if (m_idx == 0) begin
                    if (!m_near && near) rise = n;
                    m_s0 = num0; m_s1 = num1; m_near = near;
                end
                m_an = ~(4'b0001 << m_idx);
                case (m_idx)
                    0: m_seg = phase_at(n) ? glyph(m_s0) : 8'hFF;
                    1: m_seg = (phase_at(n) && !(m_s1 == 0 && m_s0 <= 9)) ? glyph(m_s1) : 8'hFF;
                    2: m_seg = 8'hFF;
                    default: m_seg = m_near ? 8'hAB : 8'hFF;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("model_seg", {24'd0, seg}, {24'd0, m_seg});
            chk("model_an", {28'd0, an}, {28'd0, m_an});
            chk("model_buzzer", {31'd0, buzzer}, {31'd0, m_buz});
        end
    end

    task automatic wait_an(input logic [3:0] pat, input string name);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (an == pat) return;
        end
        chk({name, "_timeout"}, {28'd0, an}, {28'd0, pat});
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int len;
        bit seen;
        repeat (3) @(negedge clk);
        chk("reset_seg", {24'd0, seg}, 32'hFF);
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_buzzer", {31'd0, buzzer}, 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_first_slot_an", {28'd0, an}, 32'hF);
        @(negedge clk);
        chk("first_slot_an", {28'd0, an}, 32'hE);
        chk("first_slot_seg", {24'd0, seg}, 32'hBF);

        num1 = 4'd3; num0 = 4'd7;
        settle();
        wait_an(4'b1110, "two_digit");
        chk("units_7", {24'd0, seg}, 32'hF8);
        len = 1;
        while (an == 4'b1110 && len < 20) begin @(negedge clk); if (an == 4'b1110) len++; end
        chk("slot_length", len, 4);
        chk("tens_3_an", {28'd0, an}, 32'hD);
        chk("tens_3", {24'd0, seg}, 32'hB0);
        wait_an(4'b1011, "idx2");
        chk("idx2_blank", {24'd0, seg}, 32'hFF);
        wait_an(4'b0111, "idx3");
        chk("idx3_blank", {24'd0, seg}, 32'hFF);

        num1 = 4'd0; num0 = 4'd5;
        settle();
        wait_an(4'b1101, "lz_tens");
        chk("leading_zero", {24'd0, seg}, 32'hFF);
        wait_an(4'b1110, "lz_units");
        chk("units_5", {24'd0, seg}, 32'h92);

        num1 = 4'd10; num0 = 4'd11;
        settle();
        wait_an(4'b1110, "inv_units");
        chk("invalid_units", {24'd0, seg}, 32'hFF);
        wait_an(4'b1101, "inv_tens");
        chk("invalid_tens", {24'd0, seg}, 32'hFF);

        near = 1'b1; num1 = 4'd2; num0 = 4'd5;
        settle();
        wait_an(4'b0111, "near_n");
        chk("near_glyph_n", {24'd0, seg}, 32'hAB);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && seg == 8'hFF) seen = 1'b1;
        end
        chk("blink_off_seen", {31'd0, seen}, 32'h1);
        repeat (80) @(negedge clk);

        near = 1'b0; num1 = 4'd0; num0 = 4'd4;
        settle();
        wait_an(4'b1110, "tear_pre");
        num0 = 4'd9;
        @(negedge clk);
        chk("tear_hold_4", {24'd0, seg}, 32'h99);
        wait_an(4'b1101, "tear_mid");
        wait_an(4'b1110, "tear_post");
        chk("tear_new_9", {24'd0, seg}, 32'h90);

        near = 1'b1; num1 = 4'd1; num0 = 4'd8;
        settle();
        for (int i = 0; i < 200 && phase_at(n); i++) @(negedge clk);
        near = 1'b0;
        repeat (24) @(negedge clk);
        wait_an(4'b1110, "drop_units");
        chk("drop_lit", {24'd0, seg}, 32'h80);
        chk("drop_buzzer", {31'd0, buzzer}, 32'h0);

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                num0 = 4'($urandom_range(0, 15));
                num1 = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 39) == 0) near = ~near;
            if (c == 1234) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("midframe_rst_seg", {24'd0, seg}, 32'hFF);
                chk("midframe_rst_an", {28'd0, an}, 32'hF);
                chk("midframe_rst_buzzer", {31'd0, buzzer}, 32'h0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
